// File: rtl/output_buffer_pkg.sv
// Definitions shared by the accumulator and the output buffer: buffer geometry
// and the drain FSM state encoding.
package output_buffer_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int OCC_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } drain_state_e;

endpackage

// File: rtl/output_buffer.sv
// Result buffer: stores accumulator writes by address, tracks unread entries and
// drains them in ascending address order over a valid/ready stream.
module output_buffer
  import output_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic              clear,
  input  logic              drain_start,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              drain_busy,
  output logic              drain_done,
  output logic [OCC_W-1:0]  occupancy,
  output logic              overwrite_err,
  output drain_state_e      drain_state
);

  // Stream handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; once raised, out_valid and the word stay put until
  // that transfer (only clear/rst may withdraw them). out_ready may toggle freely.

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [OCC_W-1:0]  r_occ;
  logic              r_err;
  drain_state_e      r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid;
  logic              r_done;

  logic w_flush;
  logic w_hs;
  logic w_wr_hits_hs;
  logic w_wr_new;
  logic w_idx_last;

  assign w_flush      = rst | clear;
  assign w_hs         = (r_state == SEND) & r_out_valid & out_ready;
  assign w_wr_hits_hs = w_hs & wr_en & (wr_addr == r_idx);
  // A rewrite of the entry leaving this cycle counts as new, cancelling its decrement.
  assign w_wr_new     = wr_en & (~r_valid[wr_addr] | w_wr_hits_hs);
  assign w_idx_last   = (r_idx == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (wr_en && !w_flush) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_valid <= '0;
      r_occ   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_valid[r_idx] <= 1'b0;
      end
      // Placed after the handshake clear so a same-cycle rewrite keeps the entry valid.
      if (wr_en) begin
        r_valid[wr_addr] <= 1'b1;
      end
      if (wr_en && r_valid[wr_addr] && !w_wr_hits_hs) begin
        r_err <= 1'b1;
      end
      case ({w_wr_new, w_hs})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      if (rst) begin
        r_idx      <= '0;
        r_out_data <= '0;
        r_out_addr <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (drain_start) begin
            r_idx   <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (r_valid[r_idx]) begin
            r_out_data  <= r_mem[r_idx];
            r_out_addr  <= r_idx;
            r_out_valid <= 1'b1;
            r_state     <= SEND;
          end else if (w_idx_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + ADDR_W'(1);
          end
        end
        SEND: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            if (w_idx_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= SCAN;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_data      = r_out_data;
  assign out_addr      = r_out_addr;
  assign out_valid     = r_out_valid;
  assign drain_busy    = (r_state != IDLE);
  assign drain_done    = r_done;
  assign occupancy     = r_occ;
  assign overwrite_err = r_err;
  assign drain_state   = r_state;

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: vector table, directed drain sequences
// and randomized write/drain rounds against an array-and-queue reference model.
module tb_output_buffer;
  import output_buffer_pkg::*;

  localparam int WW = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic              wr_en = 1'b0;
  logic              clear = 1'b0;
  logic              drain_start = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              drain_busy;
  logic              drain_done;
  logic [OCC_W-1:0]  occupancy;
  logic              overwrite_err;
  drain_state_e      dbg_state;

  output_buffer dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .clear(clear), .drain_start(drain_start), .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready), .drain_busy(drain_busy),
    .drain_done(drain_done), .occupancy(occupancy), .overwrite_err(overwrite_err),
    .drain_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [WW-1:0]    exp_q[$];
  logic [OCC_W-1:0] occ_log[$];
  logic [OCC_W-1:0] occ_prev = '0;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              clr;
    logic [OCC_W-1:0]  exp_occ;
    logic              exp_err;
  } vec_t;
  vec_t vecs[10];

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_val [DEPTH];
  int                m_occ;
  logic              m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: scores any transfer happening at this edge, then samples 1ns later.
  task automatic step();
    logic          hs;
    logic          hold;
    logic [WW-1:0] prev_w;
    hs     = out_valid && out_ready;
    hold   = out_valid && !out_ready && !clear && !rst;
    prev_w = {out_addr, out_data};
    if (hs) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none", prev_w);
      end else begin
        check("drain_word", prev_w, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_word", {out_addr, out_data}, prev_w);
    end
    if (drain_done) done_cnt++;
    if (occupancy != occ_prev) occ_log.push_back(occupancy);
    occ_prev = occupancy;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic finish_drain(input bit rand_ready);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      n++;
    end
    check("drain_finished", done_cnt, 1);
    check("drain_queue_empty", exp_q.size(), 0);
    step();
    check("idle_after_done", {drain_busy, drain_done}, 0);
  endtask

  task automatic run_drain(input bit rand_ready);
    done_cnt = 0;
    out_ready = 1'b1;
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    finish_drain(rand_ready);
  endtask

  // Starts a drain with out_ready low and waits for the first presented word.
  task automatic start_until_valid(output int k);
    done_cnt = 0;
    out_ready = 1'b0;
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      step();
      k++;
    end
    check("word_presented", out_valid, 1);
  endtask

  initial begin
    int k;
    int seen_valid;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;

    vecs[0] = '{1'b1, 4'd3,  32'h0000_1111, 1'b0, 5'd1, 1'b0};
    vecs[1] = '{1'b1, 4'd9,  32'h0000_2222, 1'b0, 5'd2, 1'b0};
    vecs[2] = '{1'b0, 4'd9,  32'h0000_3333, 1'b0, 5'd2, 1'b0};
    vecs[3] = '{1'b1, 4'd3,  32'h0000_4444, 1'b0, 5'd2, 1'b1};
    vecs[4] = '{1'b0, 4'd0,  32'h0000_0000, 1'b1, 5'd0, 1'b0};
    vecs[5] = '{1'b1, 4'd2,  32'h0000_5555, 1'b0, 5'd1, 1'b0};
    vecs[6] = '{1'b1, 4'd2,  32'h0000_6666, 1'b0, 5'd1, 1'b1};
    vecs[7] = '{1'b1, 4'd15, 32'h0000_7777, 1'b0, 5'd2, 1'b1};
    vecs[8] = '{1'b1, 4'd7,  32'h0000_8888, 1'b1, 5'd0, 1'b0};
    vecs[9] = '{1'b1, 4'd0,  32'h0000_9999, 1'b0, 5'd1, 1'b0};

    // Reset
    step(); step();
    rst = 1'b0;
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", drain_busy, 0);
    check("rst_done", drain_done, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_overwrite_err", overwrite_err, 0);
    check("rst_state", dbg_state, IDLE);

    // Table: write/clear vectors with expected occupancy and error flag
    for (int i = 0; i < 10; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].addr; wr_data = vecs[i].data; clear = vecs[i].clr;
      step();
      check($sformatf("vec%0d_occ", i), occupancy, vecs[i].exp_occ);
      check($sformatf("vec%0d_err", i), overwrite_err, vecs[i].exp_err);
    end
    wr_en = 1'b0; clear = 1'b0;
    exp_q.push_back({4'd0, 32'h0000_9999});
    run_drain(0);

    // Two entries, ready tied high
    do_clear();
    wr(4'd3, 32'hAAAA_0001);
    wr(4'd9, 32'hBBBB_0002);
    check("seq1_occ_start", occupancy, 2);
    exp_q.push_back({4'd3, 32'hAAAA_0001});
    exp_q.push_back({4'd9, 32'hBBBB_0002});
    occ_log.delete();
    run_drain(0);
    check("seq1_occ_steps", occ_log.size(), 2);
    if (occ_log.size() == 2) begin
      check("seq1_occ_first", occ_log[0], 1);
      check("seq1_occ_second", occ_log[1], 0);
    end
    check("seq1_err", overwrite_err, 0);

    // Empty buffer: drain_done exactly 17 cycles after drain_start
    do_clear();
    done_cnt = 0;
    out_ready = 1'b1;
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    check("empty_busy", drain_busy, 1);
    k = 0;
    seen_valid = 0;
    while (!drain_done && k < 40) begin
      step();
      k++;
      if (out_valid) seen_valid++;
    end
    check("empty_done_latency", k, 16);
    check("empty_no_valid", seen_valid, 0);
    step();
    check("empty_idle_after", {drain_done, drain_busy}, 0);
    check("empty_state_idle", dbg_state, IDLE);

    // Back-pressure on entry 5
    do_clear();
    wr(4'd5, 32'hC0DE_0005);
    start_until_valid(k);
    check("bp_latency", k, 6);
    check("bp_addr", out_addr, 5);
    check("bp_data", out_data, 32'hC0DE_0005);
    for (int i = 0; i < 10; i++) step();
    exp_q.push_back({4'd5, 32'hC0DE_0005});
    finish_drain(0);
    check("bp_occ", occupancy, 0);

    // Double write without drain
    do_clear();
    wr(4'd2, 32'h1234_0001);
    wr(4'd2, 32'h1234_0002);
    check("ow_err", overwrite_err, 1);
    check("ow_occ", occupancy, 1);
    exp_q.push_back({4'd2, 32'h1234_0002});
    run_drain(0);
    check("ow_err_sticky", overwrite_err, 1);

    // Writes during a drain held at idx 6
    do_clear();
    wr(4'd6, 32'h6666_0006);
    start_until_valid(k);
    check("mid_addr", out_addr, 6);
    wr(4'd12, 32'h0C0C_000C);
    wr(4'd1, 32'h0101_0001);
    check("mid_occ", occupancy, 3);
    exp_q.push_back({4'd6, 32'h6666_0006});
    exp_q.push_back({4'd12, 32'h0C0C_000C});
    finish_drain(0);
    check("mid_occ_after", occupancy, 1);
    check("mid_err", overwrite_err, 0);
    exp_q.push_back({4'd1, 32'h0101_0001});
    run_drain(0);
    check("mid_occ_next", occupancy, 0);

    // Rewrite of the entry on its handshake cycle
    do_clear();
    wr(4'd4, 32'h4444_000A);
    start_until_valid(k);
    exp_q.push_back({4'd4, 32'h4444_000A});
    out_ready = 1'b1;
    wr(4'd4, 32'h4444_000B);
    check("rw_occ", occupancy, 1);
    check("rw_err", overwrite_err, 0);
    finish_drain(0);
    exp_q.push_back({4'd4, 32'h4444_000B});
    run_drain(0);
    check("rw_occ_after", occupancy, 0);

    // clear in SEND beats a simultaneous write
    do_clear();
    wr(4'd3, 32'h3333_0003);
    start_until_valid(k);
    clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEAD_0000;
    step();
    clear = 1'b0; wr_en = 1'b0;
    check("clr_valid", out_valid, 0);
    check("clr_state", dbg_state, IDLE);
    check("clr_occ", occupancy, 0);
    run_drain(0);
    check("clr_occ_after", occupancy, 0);

    // Random rounds against the reference model
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin m_val[i] = 1'b0; m_mem[i] = '0; end
    m_occ = 0;
    m_err = 1'b0;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < $urandom_range(3, 30); c++) begin
        wr_en = ($urandom_range(0, 2) != 0);
        a = ADDR_W'($urandom_range(0, DEPTH - 1));
        d = $urandom;
        wr_addr = a;
        wr_data = d;
        clear = ($urandom_range(0, 39) == 0);
        if (clear) begin
          for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
          m_occ = 0;
          m_err = 1'b0;
        end else if (wr_en) begin
          if (m_val[a]) m_err = 1'b1;
          else m_occ++;
          m_val[a] = 1'b1;
          m_mem[a] = d;
        end
        step();
        check("rnd_occ", occupancy, m_occ);
        check("rnd_err", overwrite_err, m_err);
      end
      wr_en = 1'b0;
      clear = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_val[i]) exp_q.push_back({ADDR_W'(i), m_mem[i]});
        m_val[i] = 1'b0;
      end
      m_occ = 0;
      run_drain(1);
      check("rnd_occ_drained", occupancy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
